// File: rtl/duck_draw_engine_if.sv
// Command/pixel bundle between the duck movement FSM, the draw engine and the VGA adapter.
// The master drives the command code and object select; the slave returns pixels and positions.
interface duck_draw_engine_if;
    logic [3:0] STATE;
    logic       PorB;
    logic       doneDrawing;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] bird_x;
    logic [7:0] cross_x;
    logic [6:0] bird_y;
    logic [6:0] cross_y;

    modport master (
        output STATE, PorB,
        input  doneDrawing, vga_x, vga_y, colour, plot,
        input  bird_x, cross_x, bird_y, cross_y
    );

    modport slave (
        input  STATE, PorB,
        output doneDrawing, vga_x, vga_y, colour, plot,
        output bird_x, cross_x, bird_y, cross_y
    );
endinterface

// File: rtl/duck_draw_engine.sv
// Bird/crosshair position keeper and sprite-box pixel sweeper for the duck-hunt VGA path.
// One pixel per cycle; doneDrawing closes the FSM's wait loop on clear and draw commands.
module duck_draw_engine #(
    parameter int unsigned    SPRITE_W     = 8,
    parameter int unsigned    SPRITE_H     = 8,
    parameter int unsigned    X_MAX        = 152,
    parameter int unsigned    Y_MAX        = 112,
    parameter int unsigned    STEP         = 2,
    parameter int unsigned    BIRD_X0      = 0,
    parameter int unsigned    BIRD_Y0      = 56,
    parameter int unsigned    CROSS_X0     = 76,
    parameter int unsigned    CROSS_Y0     = 56,
    parameter logic [2:0]     BG_COLOUR    = 3'b011,
    parameter logic [2:0]     BIRD_COLOUR  = 3'b110,
    parameter logic [2:0]     CROSS_COLOUR = 3'b100
) (
    input  logic              clk,
    input  logic              reset_n,
    duck_draw_engine_if.slave bus
);

    localparam int unsigned N_PIX = SPRITE_W * SPRITE_H;
    localparam int unsigned CNT_W = $clog2(N_PIX);
    localparam int unsigned XW    = $clog2(SPRITE_W);
    localparam int unsigned YW    = CNT_W - XW;

    localparam logic [3:0] CMD_CLEAR = 4'b0001;
    localparam logic [3:0] CMD_LEFT  = 4'b0011;
    localparam logic [3:0] CMD_RIGHT = 4'b0010;
    localparam logic [3:0] CMD_DOWN  = 4'b0110;
    localparam logic [3:0] CMD_UP    = 4'b0111;
    localparam logic [3:0] CMD_DRAW  = 4'b0101;

    localparam logic [XW-1:0]    CX_MID  = XW'(SPRITE_W / 2);
    localparam logic [YW-1:0]    CY_MID  = YW'(SPRITE_H / 2);
    localparam logic [8:0]       STEP9   = 9'(STEP);
    localparam logic [8:0]       XMAX9   = 9'(X_MAX);
    localparam logic [8:0]       YMAX9   = 9'(Y_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Saturating step toward zero, evaluated wide so the subtraction never wraps.
    function automatic logic [8:0] sat_dec(input logic [8:0] v);
        sat_dec = (v < STEP9) ? 9'd0 : (v - STEP9);
    endfunction

    // Saturating step toward the limit, evaluated wide so the addition never wraps.
    function automatic logic [8:0] sat_inc(input logic [8:0] v, input logic [8:0] lim);
        sat_inc = (v > (lim - STEP9)) ? lim : (v + STEP9);
    endfunction

    logic [3:0]       prev_state_r;
    logic             busy_r;
    logic             op_draw_r;
    logic             obj_r;
    logic [7:0]       base_x_r;
    logic [6:0]       base_y_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       bird_x_r;
    logic [7:0]       cross_x_r;
    logic [6:0]       bird_y_r;
    logic [6:0]       cross_y_r;
    logic [7:0]       vga_x_r;
    logic [6:0]       vga_y_r;
    logic [2:0]       colour_r;
    logic             plot_r;

    logic             new_cmd_s;
    logic             start_s;
    logic             move_s;
    logic             emit_s;
    logic             last_s;
    logic [7:0]       cur_x_s;
    logic [6:0]       cur_y_s;
    logic [7:0]       mov_x_s;
    logic [6:0]       mov_y_s;
    logic             pix_draw_s;
    logic             pix_obj_s;
    logic [7:0]       pix_bx_s;
    logic [6:0]       pix_by_s;
    logic [CNT_W-1:0] pix_idx_s;
    logic [XW-1:0]    cx_s;
    logic [YW-1:0]    cy_s;
    logic [7:0]       pix_x_s;
    logic [6:0]       pix_y_s;
    logic             pix_plot_s;
    logic [2:0]       pix_colour_s;

    // Command edge detection and sweep sequencing flags.
    always_comb begin
        new_cmd_s = (bus.STATE != prev_state_r);
        start_s   = ((bus.STATE == CMD_CLEAR) || (bus.STATE == CMD_DRAW)) && new_cmd_s && !busy_r;
        move_s    = new_cmd_s && !busy_r;
        // cnt_r names the next pixel to emit; it wraps to zero once the last one is out.
        emit_s    = start_s || (busy_r && (cnt_r != CNT_ZERO));
        last_s    = busy_r && (cnt_r == CNT_ZERO);
    end

    // Saturated next position of the selected object for the presented move code.
    always_comb begin
        cur_x_s = bus.PorB ? cross_x_r : bird_x_r;
        cur_y_s = bus.PorB ? cross_y_r : bird_y_r;
        mov_x_s = cur_x_s;
        mov_y_s = cur_y_s;
        case (bus.STATE)
            CMD_LEFT:  mov_x_s = 8'(sat_dec({1'b0, cur_x_s}));
            CMD_RIGHT: mov_x_s = 8'(sat_inc({1'b0, cur_x_s}, XMAX9));
            CMD_UP:    mov_y_s = 7'(sat_dec({2'b00, cur_y_s}));
            CMD_DOWN:  mov_y_s = 7'(sat_inc({2'b00, cur_y_s}, YMAX9));
            default: begin
                mov_x_s = cur_x_s;
                mov_y_s = cur_y_s;
            end
        endcase
    end

    // Pixel generator: the starting cycle uses live inputs, later cycles the latched job.
    always_comb begin
        if (busy_r) begin
            pix_draw_s = op_draw_r;
            pix_obj_s  = obj_r;
            pix_bx_s   = base_x_r;
            pix_by_s   = base_y_r;
            pix_idx_s  = cnt_r;
        end else begin
            pix_draw_s = (bus.STATE == CMD_DRAW);
            pix_obj_s  = bus.PorB;
            pix_bx_s   = cur_x_s;
            pix_by_s   = cur_y_s;
            pix_idx_s  = CNT_ZERO;
        end
        cx_s    = pix_idx_s[XW-1:0];
        cy_s    = pix_idx_s[CNT_W-1:XW];
        pix_x_s = pix_bx_s + 8'(cx_s);
        pix_y_s = pix_by_s + 7'(cy_s);
        if (!pix_draw_s) begin
            pix_plot_s   = 1'b1;
            pix_colour_s = BG_COLOUR;
        end else if (!pix_obj_s) begin
            pix_plot_s   = 1'b1;
            pix_colour_s = BIRD_COLOUR;
        end else begin
            pix_plot_s   = (cx_s == CX_MID) || (cy_s == CY_MID);
            pix_colour_s = CROSS_COLOUR;
        end
    end

    // Previous command code, reset to an unused code so the first CLEAR reads as new.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_state_r <= 4'hF;
        end else begin
            prev_state_r <= bus.STATE;
        end
    end

    // Sweep job latch and pixel counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r    <= 1'b0;
            op_draw_r <= 1'b0;
            obj_r     <= 1'b0;
            base_x_r  <= 8'd0;
            base_y_r  <= 7'd0;
            cnt_r     <= CNT_ZERO;
        end else if (start_s) begin
            busy_r    <= 1'b1;
            op_draw_r <= (bus.STATE == CMD_DRAW);
            obj_r     <= bus.PorB;
            base_x_r  <= cur_x_s;
            base_y_r  <= cur_y_s;
            cnt_r     <= CNT_ONE;
        end else if (busy_r) begin
            cnt_r  <= cnt_r + CNT_ONE;
            busy_r <= !last_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Object positions; moves are locked out while a sweep is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bird_x_r  <= 8'(BIRD_X0);
            bird_y_r  <= 7'(BIRD_Y0);
            cross_x_r <= 8'(CROSS_X0);
            cross_y_r <= 7'(CROSS_Y0);
        end else if (move_s && bus.PorB) begin
            cross_x_r <= mov_x_s;
            cross_y_r <= mov_y_s;
        end else if (move_s) begin
            bird_x_r <= mov_x_s;
            bird_y_r <= mov_y_s;
        end else begin
            bird_x_r <= bird_x_r;
        end
    end

    // Registered VGA pixel stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_x_r  <= 8'd0;
            vga_y_r  <= 7'd0;
            colour_r <= 3'd0;
            plot_r   <= 1'b0;
        end else if (emit_s) begin
            vga_x_r  <= pix_x_s;
            vga_y_r  <= pix_y_s;
            colour_r <= pix_colour_s;
            plot_r   <= pix_plot_s;
        end else begin
            plot_r <= 1'b0;
        end
    end

    assign bus.doneDrawing = ~busy_r & ~start_s;
    assign bus.vga_x       = vga_x_r;
    assign bus.vga_y       = vga_y_r;
    assign bus.colour      = colour_r;
    assign bus.plot        = plot_r;
    assign bus.bird_x      = bird_x_r;
    assign bus.bird_y      = bird_y_r;
    assign bus.cross_x     = cross_x_r;
    assign bus.cross_y     = cross_y_r;

endmodule

// File: tb/tb_duck_draw_engine.sv
// Directed and randomized bench for duck_draw_engine against a position/sprite reference model.
module tb_duck_draw_engine;

    localparam logic [3:0] C_CLEAR = 4'b0001;
    localparam logic [3:0] C_LEFT  = 4'b0011;
    localparam logic [3:0] C_RIGHT = 4'b0010;
    localparam logic [3:0] C_DOWN  = 4'b0110;
    localparam logic [3:0] C_UP    = 4'b0111;
    localparam logic [3:0] C_DRAW  = 4'b0101;
    localparam logic [3:0] C_NOP   = 4'b0000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   pos_x [2];
    int   pos_y [2];

    duck_draw_engine_if bus ();

    duck_draw_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos_x[0] = 0;  pos_y[0] = 56;
        pos_x[1] = 76; pos_y[1] = 56;
    endtask

    task automatic check_pos(input string tag);
        chk({tag, "_bird_x"},  bus.bird_x,  pos_x[0]);
        chk({tag, "_bird_y"},  bus.bird_y,  pos_y[0]);
        chk({tag, "_cross_x"}, bus.cross_x, pos_x[1]);
        chk({tag, "_cross_y"}, bus.cross_y, pos_y[1]);
    endtask

    // One move command held for one cycle, then a no-op so the next command is new.
    task automatic do_move(input logic [3:0] code, input logic obj);
        int o;
        o = obj ? 1 : 0;
        @(posedge clk); #1;
        bus.STATE = code;
        bus.PorB  = obj;
        @(negedge clk);
        check_pos("move_before");
        case (code)
            C_LEFT:  pos_x[o] = (pos_x[o] < 2)   ? 0   : pos_x[o] - 2;
            C_RIGHT: pos_x[o] = (pos_x[o] > 150) ? 152 : pos_x[o] + 2;
            C_UP:    pos_y[o] = (pos_y[o] < 2)   ? 0   : pos_y[o] - 2;
            C_DOWN:  pos_y[o] = (pos_y[o] > 110) ? 112 : pos_y[o] + 2;
            default: ;
        endcase
        @(posedge clk); #1;
        bus.STATE = C_NOP;
        @(negedge clk);
        check_pos("move_after");
    endtask

    // Full sprite sweep with optional mid-sweep command injection or reset abort.
    task automatic sweep(input logic [3:0] code, input logic obj, input int inj_idx,
                         input logic [3:0] inj_code, input int abort_idx, output int plots);
        int bx, by, cx, cy, o, ecol;
        logic eplot;
        o = obj ? 1 : 0;
        plots = 0;
        @(posedge clk); #1;
        bus.STATE = code;
        bus.PorB  = obj;
        bx = pos_x[o];
        by = pos_y[o];
        @(negedge clk);
        chk("start_done_low", bus.doneDrawing, 0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cx = i % 8;
            cy = i / 8;
            eplot = (code == C_CLEAR) || (o == 0) || (cx == 4) || (cy == 4);
            ecol  = (code == C_CLEAR) ? 3 : ((o == 1) ? 4 : 6);
            chk("sweep_done_low", bus.doneDrawing, 0);
            chk("sweep_x", bus.vga_x, bx + cx);
            chk("sweep_y", bus.vga_y, by + cy);
            chk("sweep_plot", bus.plot, eplot);
            if (eplot) chk("sweep_colour", bus.colour, ecol);
            if (bus.plot === 1'b1) plots++;
            if (i == inj_idx) begin
                bus.STATE = inj_code;
                bus.PorB  = ~obj;
            end
            if (i == abort_idx) begin
                reset_n   = 1'b0;
                bus.STATE = C_NOP;
                #1;
                model_reset();
                chk("abort_plot", bus.plot, 0);
                chk("abort_done", bus.doneDrawing, 1);
                chk("abort_vga_x", bus.vga_x, 0);
                check_pos("abort");
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        chk("end_done_high", bus.doneDrawing, 1);
        chk("end_plot_low", bus.plot, 0);
    endtask

    initial begin
        int plots, lows, o;
        logic [3:0] code, cur;
        bus.STATE = C_NOP;
        bus.PorB  = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #20;
        bus.STATE = C_CLEAR;
        #1 chk("reset_clear_done_low", bus.doneDrawing, 0);
        bus.STATE = C_NOP;
        #1 chk("reset_nop_done_high", bus.doneDrawing, 1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_plot", bus.plot, 0);
        chk("reset_vga_x", bus.vga_x, 0);
        chk("reset_vga_y", bus.vga_y, 0);
        chk("reset_colour", bus.colour, 0);
        check_pos("reset");

        // Clear bird, then back-to-back draw of crosshair.
        sweep(C_CLEAR, 1'b0, -1, C_NOP, -1, plots);
        chk("clear_plot_count", plots, 64);
        sweep(C_DRAW, 1'b1, -1, C_NOP, -1, plots);
        chk("cross_plot_count", plots, 15);

        // Boundary walks: crosshair to x=0, bird to x=152, bird up past y=0, crosshair down to 112.
        for (int i = 0; i < 40; i++) do_move(C_LEFT, 1'b1);
        for (int i = 0; i < 78; i++) do_move(C_RIGHT, 1'b0);
        for (int i = 0; i < 30; i++) do_move(C_UP, 1'b0);
        for (int i = 0; i < 30; i++) do_move(C_DOWN, 1'b1);

        // Randomized moves including no-op codes.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: code = C_LEFT;
                1: code = C_RIGHT;
                2: code = C_UP;
                3: code = C_DOWN;
                4: code = 4'b1000;
                default: code = 4'b0100;
            endcase
            do_move(code, 1'($urandom_range(0, 1)));
        end

        // Randomized sweeps at the current random positions.
        cur = C_NOP;
        for (int i = 0; i < 6; i++) begin
            code = ($urandom_range(0, 1) == 0) ? C_CLEAR : C_DRAW;
            o = int'($urandom_range(0, 1));
            if (code == cur) begin
                @(posedge clk); #1 bus.STATE = C_NOP;
            end
            sweep(code, 1'(o), -1, C_NOP, -1, plots);
            chk("rand_plot_count", plots, (code == C_DRAW && o == 1) ? 15 : 64);
            cur = code;
        end

        // Move injected mid-sweep is ignored and the sweep still completes.
        @(posedge clk); #1 bus.STATE = C_NOP;
        sweep(C_DRAW, 1'b0, 10, C_DOWN, -1, plots);
        chk("inject_plot_count", plots, 64);
        check_pos("inject_after");
        @(posedge clk); #1 bus.STATE = C_NOP;
        @(negedge clk);
        check_pos("inject_settled");

        // Reset mid-draw, then a full clear.
        sweep(C_DRAW, 1'b0, -1, C_NOP, 30, plots);
        sweep(C_CLEAR, 1'b0, -1, C_NOP, -1, plots);
        chk("post_reset_clear_count", plots, 64);

        // DRAW held for 200 cycles starts exactly one sweep.
        @(posedge clk); #1;
        bus.STATE = C_DRAW;
        bus.PorB  = 1'b0;
        plots = 0;
        lows  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.plot === 1'b1) plots++;
            if (bus.doneDrawing !== 1'b1) lows++;
        end
        chk("hold_plot_count", plots, 64);
        chk("hold_done_low_cycles", lows, 65);
        chk("hold_done_final", bus.doneDrawing, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
